// File: rtl/lzx_vm_sched.sv
// rtl/lzx_vm_sched.sv - two-channel vending scheduler with shared dispenser
//
// Each channel accumulates coin credit. A round-robin arbiter hands the
// shared dispenser to a channel whose credit reaches PRICE. The transaction
// FSM (IDLE/REQ/CHG) then runs the dispense handshake and pays out the
// remaining credit as one-cycle change pulses.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   coin0, coin1      per-channel coin: 00 none, 01 +1, 10 +2, 11 ignored
//   disp_ack          dispenser accept level, only looked at in REQ
//   disp_req, disp_ch dispense request and owning channel
//   D_out, C          per-channel delivered pulse / change pulse (0.5 yuan)
//   coin_rej          per-channel coin-reject pulse
//   busy, fault       FSM not idle / sticky dispense timeout
//
// Optional feature: define LZX_VM_TIMEOUT_EN to give up on the dispenser
// after TIMEOUT cycles in REQ, refund the full credit and raise fault.
// Without it REQ waits indefinitely and fault is tied low.
module lzx_vm_sched #(
  parameter int PRICE      = 3,
  parameter int CW         = 4,
  parameter int CREDIT_MAX = 6,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] coin0,
  input  logic [1:0] coin1,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic       disp_ch,
  output logic [1:0] D_out,
  output logic [1:0] C,
  output logic [1:0] coin_rej,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_CHG = 2'd2} state_t;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW:0]   MAX_C   = (CW+1)'(CREDIT_MAX);

  // Elaboration-time sanity: credit must never wrap, timeout must be nonzero.
  if (CREDIT_MAX >= (1 << CW) || TIMEOUT < 1) begin : g_param_check
    $error("lzx_vm_sched: bad parameter set");
  end

  state_t             state_q;
  logic [1:0][CW-1:0] credit_q, credit_d;
  logic [1:0][1:0]    coin_w, val_w;
  logic [1:0][CW:0]   sum_w;
  logic [1:0]         rej_d, rej_q, d_out_q, c_q, elig;
  logic               rr_q, ch_q, req_q, busy_q, grant;
  logic [CW-1:0]      own_credit, own_rem;

  assign coin_w     = {coin1, coin0};
  assign own_credit = credit_q[ch_q];
  assign own_rem    = own_credit - PRICE_C;

  // Coin acceptance. The owned channel (REQ/CHG) refuses coins so that the
  // credit being paid out cannot change underneath the FSM.
  always_comb begin
    credit_d = credit_q;
    rej_d    = '0;
    val_w    = '0;
    sum_w    = '0;
    for (int i = 0; i < 2; i++) begin
      val_w[i] = (coin_w[i] == 2'b11) ? 2'b00 : coin_w[i];
      sum_w[i] = {1'b0, credit_q[i]} + (CW+1)'(val_w[i]);
      if (val_w[i] != 2'b00) begin
        if ((state_q != S_IDLE && ch_q == 1'(i)) || sum_w[i] > MAX_C)
          rej_d[i] = 1'b1;
        else
          credit_d[i] = sum_w[i][CW-1:0];
      end
    end
  end

  // Round robin only matters when both are eligible; otherwise take the one.
  always_comb begin
    elig[0] = credit_q[0] >= PRICE_C;
    elig[1] = credit_q[1] >= PRICE_C;
    grant   = (&elig) ? rr_q : ~elig[0];
  end

`ifdef LZX_VM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      rr_q     <= 1'b0;
      ch_q     <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      d_out_q  <= '0;
      c_q      <= '0;
      rej_q    <= '0;
`ifdef LZX_VM_TIMEOUT_EN
      tmo_q    <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      credit_q <= credit_d;
      rej_q    <= rej_d;
      d_out_q  <= '0;
      c_q      <= '0;
      case (state_q)
        S_IDLE: begin
          if (|elig) begin
            state_q <= S_REQ;
            ch_q    <= grant;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
`ifdef LZX_VM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (disp_ack) begin
            req_q             <= 1'b0;
            d_out_q[ch_q]     <= 1'b1;
            credit_q[ch_q]    <= own_rem;
            if (own_rem == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              rr_q    <= ~ch_q;
            end else begin
              state_q <= S_CHG;
            end
          end
`ifdef LZX_VM_TIMEOUT_EN
          // Credit is at least PRICE here, so the refund in CHG is non-empty.
          else if (tmo_q == TW'(TIMEOUT - 1)) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            state_q <= S_CHG;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        S_CHG: begin
          c_q[ch_q]      <= 1'b1;
          credit_q[ch_q] <= own_credit - CW'(1);
          if (own_credit == CW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rr_q    <= ~ch_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign disp_req = req_q;
  assign disp_ch  = ch_q;
  assign D_out    = d_out_q;
  assign C        = c_q;
  assign coin_rej = rej_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lzx_vm_sched.sv
// tb/tb_lzx_vm_sched.sv - directed vector table plus randomized model check
module tb_lzx_vm_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin0 = '0, coin1 = '0;
  logic       disp_ack = 1'b0;
  logic       disp_req, disp_ch, busy, fault;
  logic [1:0] D_out, C, coin_rej;
  logic [9:0] outs;

  int n_vec = 0;
  int n_bad = 0;

  lzx_vm_sched dut (
    .clk(clk), .rst_n(rst_n), .coin0(coin0), .coin1(coin1),
    .disp_ack(disp_ack), .disp_req(disp_req), .disp_ch(disp_ch),
    .D_out(D_out), .C(C), .coin_rej(coin_rej), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // {disp_req, disp_ch, D_out, C, coin_rej, busy, fault}
  assign outs = {disp_req, disp_ch, D_out, C, coin_rej, busy, fault};

  typedef struct {
    logic [1:0] c0;
    logic [1:0] c1;
    logic       ack;
    logic [9:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [1:0] c0, input logic [1:0] c1, input logic ack,
                              input logic req, input logic ch, input logic [1:0] d,
                              input logic [1:0] c, input logic [1:0] rej, input logic bsy);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.ack = ack;
    v.exp = {req, ch, d, c, rej, bsy, 1'b0};
    return v;
  endfunction

  task automatic check(input string nm, input logic [9:0] exp);
    n_vec++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (req,ch,D,C,rej,busy,fault)", nm, outs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic k);
    coin0 = a; coin1 = b; disp_ack = k;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    coin0 = '0; coin1 = '0; disp_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Behavioural reference: credit per channel, a phase (0 idle, 1 waiting
  // for the dispenser, 2 paying change), owner and round-robin preference.
  int         m_cr[2];
  int         m_ph, m_own, m_rr, m_wait;
  logic       m_req, m_fault;
  logic [1:0] m_d, m_c, m_rej;

  task automatic model_reset();
    m_cr[0] = 0; m_cr[1] = 0;
    m_ph = 0; m_own = 0; m_rr = 0; m_wait = 0;
    m_req = 0; m_fault = 0; m_d = 0; m_c = 0; m_rej = 0;
  endtask

  task automatic model_step(input logic [1:0] c0, input logic [1:0] c1, input logic ack);
    int nc[2];
    int v;
    logic [1:0] cc[2];
    cc[0] = c0; cc[1] = c1;
    nc = m_cr;
    m_d = 0; m_c = 0; m_rej = 0;
    for (int i = 0; i < 2; i++) begin
      v = (cc[i] == 2'b11) ? 0 : int'(cc[i]);
      if (v != 0) begin
        if ((m_ph != 0 && m_own == i) || m_cr[i] + v > 6) m_rej[i] = 1'b1;
        else nc[i] = nc[i] + v;
      end
    end
    case (m_ph)
      0: if (m_cr[0] >= 3 || m_cr[1] >= 3) begin
           m_own  = (m_cr[0] >= 3 && m_cr[1] >= 3) ? m_rr : (m_cr[0] >= 3 ? 0 : 1);
           m_ph   = 1; m_req = 1'b1; m_wait = 0;
         end
      1: if (ack) begin
           nc[m_own] = nc[m_own] - 3;
           m_d[m_own] = 1'b1; m_req = 1'b0;
           if (nc[m_own] == 0) begin m_ph = 0; m_rr = 1 - m_own; end
           else m_ph = 2;
         end else begin
           m_wait++;
`ifdef LZX_VM_TIMEOUT_EN
           if (m_wait == 15) begin m_req = 1'b0; m_fault = 1'b1; m_ph = 2; end
`endif
         end
      default: begin
           m_c[m_own] = 1'b1;
           nc[m_own] = nc[m_own] - 1;
           if (nc[m_own] == 0) begin m_ph = 0; m_rr = 1 - m_own; end
         end
    endcase
    m_cr = nc;
  endtask

  initial begin
    // c0, c1, ack | req, ch, D, C, rej, busy
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2, 2, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(2, 1, 1, 0, 0, 1, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(3, 3, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 2, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 2, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 2, 0, 1, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0));

    @(negedge clk);
    check("reset", 10'b0);
    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].c0, tv[i].c1, tv[i].ack);
      check($sformatf("vec%0d", i), tv[i].exp);
    end

    // Reset in the middle of a request: immediate clear, credit discarded.
    drive(2, 0, 0);
    drive(2, 0, 0);
    drive(0, 0, 0);
    check("pre_abort", 10'b1000000010);
    rst_n = 1'b0;
    #1;
    check("abort_async", 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);
    check("abort_idle0", 10'b0);
    drive(0, 0, 0);
    check("abort_idle1", 10'b0);

`ifdef LZX_VM_TIMEOUT_EN
    drive(0, 1, 0);
    drive(0, 2, 0);
    drive(0, 0, 0);
    check("tmo_grant", 10'b1100000010);
    for (int i = 1; i < 15; i++) begin
      drive(0, 0, 0);
      check($sformatf("tmo_wait%0d", i), 10'b1100000010);
    end
    drive(0, 0, 0);
    check("tmo_expire", 10'b0100000011);
    drive(0, 0, 0);
    check("tmo_ref0", 10'b0100100011);
    drive(0, 0, 0);
    check("tmo_ref1", 10'b0100100011);
    drive(0, 0, 0);
    check("tmo_ref2", 10'b0100100001);
    rst_n = 1'b0;
    #1;
    check("tmo_clear", 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      logic [1:0] a, b;
      logic k;
      a = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(0, 3))) : 2'b00;
      b = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(0, 3))) : 2'b00;
      k = ($urandom_range(0, 2) == 0);
      model_step(a, b, k);
      drive(a, b, k);
      check($sformatf("rand%0d", n),
            {m_req, 1'(m_own), m_d, m_c, m_rej, (m_ph != 0), m_fault});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
